// File: rtl/act_pkg.sv
// act_pkg: activation mode encodings shared by the activation stage and its lanes
package act_pkg;
  localparam logic [1:0] ACT_PASS  = 2'b00;
  localparam logic [1:0] ACT_RELU  = 2'b01;
  localparam logic [1:0] ACT_LEAKY = 2'b10;
  localparam logic [1:0] ACT_CLIP  = 2'b11;
endpackage

// File: rtl/leaky_relu_lane.sv
// leaky_relu_lane: registered element and leaky product (S1), then round/saturate/select (comb)
module leaky_relu_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  x,
  input  logic [ALPHA_WIDTH-1:0] alpha,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  clip,
  output logic [DATA_WIDTH-1:0]  y
);
  localparam int PW = DATA_WIDTH + ALPHA_WIDTH + 1;
  localparam logic signed [PW-1:0] MAXV = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  logic [DATA_WIDTH-1:0] x1, relu, clip_pos, clipped, leaky;
  logic signed [PW-1:0] p1, r;
  always_ff @(posedge clk)
    if (!rst_n) begin
      x1 <= '0;
      p1 <= '0;
    end else if (load) begin
      x1 <= x;
      p1 <= PW'($signed(x)) * PW'($signed({1'b0, alpha}));
    end
  // round half up, then floor via arithmetic shift
  assign r = (p1 + PW'(1 << (ALPHA_FRAC - 1))) >>> ALPHA_FRAC;
  always_comb begin
    relu = x1[DATA_WIDTH-1] ? '0 : x1;
    clip_pos = clip[DATA_WIDTH-1] ? '0 : clip;
    clipped = relu > clip_pos ? clip_pos : relu;
    leaky = !x1[DATA_WIDTH-1] ? x1 : r > MAXV ? MAXV[DATA_WIDTH-1:0] :
            r < MINV ? MINV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
    y = mode == ACT_PASS ? x1 : mode == ACT_RELU ? relu : mode == ACT_LEAKY ? leaky : clipped;
  end
endmodule

// File: rtl/leaky_relu_stream.sv
// leaky_relu_stream: 2-stage valid/ready activation pipeline with saturating negative-element counter
module leaky_relu_stream
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_LANES   = 16,
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 7,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic [1:0]                      cfg_mode,
  input  logic [ALPHA_WIDTH-1:0]          cfg_alpha,
  input  logic [DATA_WIDTH-1:0]           cfg_clip,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]            neg_count,
  input  logic                            clr_stats
);
  localparam int PC = $clog2(NUM_LANES + 1);
  localparam int SW = CNT_WIDTH + PC;
  localparam logic [SW-1:0] CMAX = SW'({CNT_WIDTH{1'b1}});
  logic s1_valid, acc, adv2;
  logic [1:0] mode1;
  logic [DATA_WIDTH-1:0] clip1;
  logic [NUM_LANES*DATA_WIDTH-1:0] y;
  logic [PC-1:0] pop;
  logic [SW-1:0] sum;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign adv2 = s1_valid && (!out_valid || out_ready);
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    leaky_relu_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ALPHA_WIDTH(ALPHA_WIDTH),
      .ALPHA_FRAC (ALPHA_FRAC)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (acc),
      .x    (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .alpha(cfg_alpha),
      .mode (mode1),
      .clip (clip1),
      .y    (y[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_LANES; i++) pop = pop + PC'(in_data[i*DATA_WIDTH+DATA_WIDTH-1]);
    sum = SW'(neg_count) + SW'(pop);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      mode1 <= ACT_PASS;
      clip1 <= '0;
      out_data <= '0;
      neg_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (acc) begin
        mode1 <= cfg_mode;
        clip1 <= cfg_clip;
      end
      if (!out_valid || out_ready) out_valid <= s1_valid;
      if (adv2) out_data <= y;
      neg_count <= clr_stats ? '0 : !acc ? neg_count :
                   sum > CMAX ? CMAX[CNT_WIDTH-1:0] : sum[CNT_WIDTH-1:0];
    end
endmodule

// File: tb/tb_leaky_relu_stream.sv
// tb_leaky_relu_stream: directed vector table plus stall, counter and reset sequences
module tb_leaky_relu_stream;
  import act_pkg::*;
  typedef struct packed {
    logic [1:0]  m;
    logic [7:0]  a;
    logic [7:0]  c;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;
  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 1, clr_stats = 0;
  logic [127:0] in_data = '0, out_data;
  logic [1:0] cfg_mode = ACT_PASS;
  logic [7:0] cfg_alpha = '0, cfg_clip = '0;
  logic [3:0] neg_count;
  int errors = 0, checks = 0, cyc = 0;
  bit chk_lat = 1;
  exp_t exp_q[$];
  exp_t e;
  vec_t tv[12];
  leaky_relu_stream #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_mode(cfg_mode), .cfg_alpha(cfg_alpha), .cfg_clip(cfg_clip), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .neg_count(neg_count), .clr_stats(clr_stats)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] c,
                      input logic [127:0] d, input logic [127:0] y);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    cfg_mode = m;
    cfg_alpha = a;
    cfg_clip = c;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{y, cyc});
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept");
    end
    in_valid = 0;
  endtask
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got %h expected no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        if (chk_lat) chk("latency", 128'(cyc - e.c), 128'd2);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{ACT_LEAKY, 8'd13,  8'h00, 32'h05FFF680, 32'h0500FFF3};
    tv[1]  = '{ACT_RELU,  8'd0,   8'h00, 32'h006404FD, 32'h00640400};
    tv[2]  = '{ACT_PASS,  8'd0,   8'h00, 32'h006404FD, 32'h006404FD};
    tv[3]  = '{ACT_CLIP,  8'd0,   8'h06, 32'h006404FD, 32'h00060400};
    tv[4]  = '{ACT_LEAKY, 8'd64,  8'h00, 32'h7F80FDFE, 32'h7FC0FFFF};
    tv[5]  = '{ACT_LEAKY, 8'd255, 8'h00, 32'h7FFEFF80, 32'h7FFCFE80};
    tv[6]  = '{ACT_LEAKY, 8'd0,   8'h00, 32'h7F80FDFE, 32'h7F000000};
    tv[7]  = '{ACT_CLIP,  8'd0,   8'hFB, 32'h006404FD, 32'h00000000};
    tv[8]  = '{ACT_CLIP,  8'd0,   8'h7F, 32'h00327F80, 32'h00327F00};
    tv[9]  = '{ACT_RELU,  8'd0,   8'h00, 32'h7F80FDFE, 32'h7F000000};
    tv[10] = '{ACT_PASS,  8'd0,   8'h00, 32'h7FFEFF80, 32'h7FFEFF80};
    tv[11] = '{ACT_LEAKY, 8'd128, 8'h00, 32'h7F80FDFE, 32'h7F80FDFE};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_neg_count", 128'(neg_count), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) send(tv[i].m, tv[i].a, tv[i].c, {96'b0, tv[i].x}, {96'b0, tv[i].y});
    repeat (4) @(posedge clk);
    #1;
    chk("drain_table", 128'(exp_q.size()), 128'd0);
    chk_lat = 0;
    out_ready = 0;
    fork
      begin
        send(tv[1].m, tv[1].a, tv[1].c, {96'b0, tv[1].x}, {96'b0, tv[1].y});
        send(tv[3].m, tv[3].a, tv[3].c, {96'b0, tv[3].x}, {96'b0, tv[3].y});
        send(tv[4].m, tv[4].a, tv[4].c, {96'b0, tv[4].x}, {96'b0, tv[4].y});
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k >= 3) begin
            chk("stall_in_ready", 128'(in_ready), 128'd0);
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_data", out_data, {96'b0, tv[1].y});
          end
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("drain_stall", 128'(exp_q.size()), 128'd0);
    chk_lat = 1;
    clr_stats = 1;
    @(posedge clk);
    #1 clr_stats = 0;
    chk("cnt_clear", 128'(neg_count), 128'd0);
    send(ACT_PASS, 8'd0, 8'd0, {88'b0, 40'hFFFFFFFFFF}, {88'b0, 40'hFFFFFFFFFF});
    chk("cnt_5", 128'(neg_count), 128'd5);
    send(ACT_PASS, 8'd0, 8'd0, {128{1'b1}}, {128{1'b1}});
    chk("cnt_sat", 128'(neg_count), 128'd15);
    send(ACT_PASS, 8'd0, 8'd0, {128{1'b1}}, {128{1'b1}});
    chk("cnt_sat_hold", 128'(neg_count), 128'd15);
    clr_stats = 1;
    send(ACT_PASS, 8'd0, 8'd0, {128{1'b1}}, {128{1'b1}});
    clr_stats = 0;
    chk("cnt_clr_wins", 128'(neg_count), 128'd0);
    send(ACT_PASS, 8'd0, 8'd0, {120'b0, 8'h80}, {120'b0, 8'h80});
    chk("cnt_1", 128'(neg_count), 128'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_cnt", 128'(exp_q.size()), 128'd0);
    out_ready = 0;
    clr_stats = 1;
    @(posedge clk);
    #1 clr_stats = 0;
    send(ACT_PASS, 8'd0, 8'd0, {112'b0, 16'hFFFF}, {112'b0, 16'hFFFF});
    send(ACT_PASS, 8'd0, 8'd0, {112'b0, 16'hFFFF}, {112'b0, 16'hFFFF});
    chk("pre_rst_cnt", 128'(neg_count), 128'd4);
    chk("pre_rst_valid", 128'(out_valid), 128'd1);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_neg_count", 128'(neg_count), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1 rst_n = 1;
    exp_q.delete();
    out_ready = 1;
    send(tv[0].m, tv[0].a, tv[0].c, {96'b0, tv[0].x}, {96'b0, tv[0].y});
    repeat (4) @(posedge clk);
    #1;
    chk("drain_final", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
